scene_ctl: RTL and testbench

//  Top-level scene sequencer. Drives the 2-bit scene select (menu=00, battle=01, endgame=10)

---
 rtl/scene_ctl.sv | 144 ++++++++++++++
 tb/tb_scene_ctl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/scene_ctl.sv
`default_nettype none
// ============================================================================
// Module     : scene_ctl
// Description: Scene sequencer for the menu / battle / endgame flow. Drives the
//              scene-mux select and a one-cycle start pulse. Scene changes are
//              latched as a pending request and committed on the next vsync
//              rising edge, so a displayed frame never tears.
// Revision   : 1.0 - initial release
// ============================================================================
module scene_ctl #(
    parameter int MIN_FRAMES     = 2,
    parameter int ENDGAME_FRAMES = 300
) (
    input  logic       i_pclk,
    input  logic       i_rst,
    input  logic       i_vs,
    input  logic       i_start,
    input  logic       i_battle_over,
    input  logic       i_winner,
    input  logic       i_restart,
    output logic [1:0] o_sel,
    output logic [2:0] o_scene_start,
    output logic       o_winner,
    output logic       o_pending
);

    // Scene encoding doubles as the mux select; 2'b11 is never produced.
    typedef enum logic [1:0] {
        S_MENU    = 2'b00,
        S_BATTLE  = 2'b01,
        S_ENDGAME = 2'b10
    } state_t;

    localparam logic [15:0] c_min_frames = 16'(MIN_FRAMES);
    localparam logic [15:0] c_eg_frames  = 16'(ENDGAME_FRAMES);
    localparam logic        c_eg_enable  = (ENDGAME_FRAMES != 0);
    localparam logic [15:0] c_dwell_max  = 16'hFFFF;

    state_t      r_state;
    state_t      r_target;
    logic        r_pend;
    logic [2:0]  r_scene_start;
    logic        r_winner;
    logic [15:0] r_dwell;
    logic        r_vs_q;

    state_t      w_state_nxt;
    state_t      w_target_nxt;
    logic        w_pend_nxt;
    logic [2:0]  w_start_nxt;
    logic        w_winner_nxt;
    logic [15:0] w_dwell_nxt;
    logic        w_tick;
    logic        w_commit;
    logic        w_can_accept;

    // Frame tick is the vsync rising edge; commit only uses a request
    // latched in an earlier cycle, so an event on a tick cycle waits one frame.
    assign w_tick       = i_vs & ~r_vs_q;
    assign w_commit     = w_tick & r_pend;
    assign w_can_accept = ~r_pend & (r_dwell >= c_min_frames);

    // Next-state, pending request, dwell counter and start pulse decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_pend_nxt   = r_pend;
        w_start_nxt  = 3'b000;
        w_winner_nxt = r_winner;
        w_dwell_nxt  = r_dwell;

        if (w_tick && (r_dwell != c_dwell_max)) begin
            w_dwell_nxt = r_dwell + 16'd1;
        end

        if (w_commit) begin
            // Commit clears dwell even when the same tick would increment it.
            w_state_nxt = r_target;
            w_pend_nxt  = 1'b0;
            w_dwell_nxt = 16'd0;
            case (r_target)
                S_MENU:    w_start_nxt = 3'b001;
                S_BATTLE:  w_start_nxt = 3'b010;
                S_ENDGAME: w_start_nxt = 3'b100;
                default:   w_start_nxt = 3'b000;
            endcase
        end else if (w_can_accept) begin
            case (r_state)
                S_MENU: begin
                    if (i_start) begin
                        w_pend_nxt   = 1'b1;
                        w_target_nxt = S_BATTLE;
                    end
                end
                S_BATTLE: begin
                    if (i_battle_over) begin
                        w_pend_nxt   = 1'b1;
                        w_target_nxt = S_ENDGAME;
                        w_winner_nxt = i_winner;
                    end
                end
                S_ENDGAME: begin
                    if (i_restart || (c_eg_enable && (r_dwell >= c_eg_frames))) begin
                        w_pend_nxt   = 1'b1;
                        w_target_nxt = S_MENU;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to menu on the next tick.
                    w_pend_nxt   = 1'b1;
                    w_target_nxt = S_MENU;
                end
            endcase
        end
    end

    // State register and all registered outputs, synchronous reset.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_state       <= S_MENU;
            r_target      <= S_MENU;
            r_pend        <= 1'b0;
            r_scene_start <= 3'b000;
            r_winner      <= 1'b0;
            r_dwell       <= 16'd0;
            r_vs_q        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_target      <= w_target_nxt;
            r_pend        <= w_pend_nxt;
            r_scene_start <= w_start_nxt;
            r_winner      <= w_winner_nxt;
            r_dwell       <= w_dwell_nxt;
            r_vs_q        <= i_vs;
        end
    end

    assign o_sel         = r_state;
    assign o_scene_start = r_scene_start;
    assign o_winner      = r_winner;
    assign o_pending     = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_scene_ctl.sv
`default_nettype none
// ============================================================================
// Module     : tb_scene_ctl
// Description: Scoreboard bench for scene_ctl. Expected start pulses are queued
//              by the stimulus thread; a monitor compares every pulse the DUT
//              emits. Two instances share inputs: one with a 5-frame endgame
//              timeout and one with the timeout disabled.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_scene_ctl;

    typedef struct packed {
        logic [1:0] sel;
        logic [2:0] start;
        logic       winner;
    } exp_t;

    logic       r_clk = 1'b0;
    logic       r_rst;
    logic       r_vs;
    logic       r_start;
    logic       r_battle_over;
    logic       r_winner;
    logic       r_restart;

    logic [1:0] w_sel5;
    logic [2:0] w_start5;
    logic       w_winner5;
    logic       w_pend5;
    logic [1:0] w_sel0;
    logic [2:0] w_start0;
    logic       w_winner0;
    logic       w_pend0;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    always #5 r_clk = ~r_clk;

    scene_ctl #(.MIN_FRAMES(2), .ENDGAME_FRAMES(5)) dut5 (
        .i_pclk(r_clk), .i_rst(r_rst), .i_vs(r_vs), .i_start(r_start),
        .i_battle_over(r_battle_over), .i_winner(r_winner), .i_restart(r_restart),
        .o_sel(w_sel5), .o_scene_start(w_start5), .o_winner(w_winner5), .o_pending(w_pend5)
    );

    scene_ctl #(.MIN_FRAMES(2), .ENDGAME_FRAMES(0)) dut0 (
        .i_pclk(r_clk), .i_rst(r_rst), .i_vs(r_vs), .i_start(r_start),
        .i_battle_over(r_battle_over), .i_winner(r_winner), .i_restart(r_restart),
        .o_sel(w_sel0), .o_scene_start(w_start0), .o_winner(w_winner0), .o_pending(w_pend0)
    );

    // Monitor: every start pulse from the timeout instance must match the
    // oldest queued expectation; a pulse with nothing queued is a failure
    // (this also catches pulses wider than one cycle).
    always @(negedge r_clk) begin
        if (w_start5 !== 3'b000) begin
            exp_t e;
            exp_t a;
            a = '{sel: w_sel5, start: w_start5, winner: w_winner5};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got sel=%b start=%b win=%b, required no pulse",
                         w_sel5, w_start5, w_winner5);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL pulse: got sel=%b start=%b win=%b, required sel=%b start=%b win=%b",
                             a.sel, a.start, a.winner, e.sel, e.start, e.winner);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    // One frame: vsync high for one cycle (the tick cycle), then low.
    task automatic tick();
        r_vs = 1'b1;
        step();
        r_vs = 1'b0;
        step();
    endtask

    task automatic pulse_start();
        r_start = 1'b1;
        step();
        r_start = 1'b0;
    endtask

    task automatic battle_over(input logic win);
        r_battle_over = 1'b1;
        r_winner      = win;
        step();
        r_battle_over = 1'b0;
        r_winner      = 1'b0;
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        r_rst = 1'b1; r_vs = 1'b0; r_start = 1'b1;
        r_battle_over = 1'b0; r_winner = 1'b0; r_restart = 1'b0;

        // 1: reset held with start asserted
        repeat (3) step();
        chk("rst_sel", 4'(w_sel5), 4'h0);
        chk("rst_pend", 4'(w_pend5), 4'h0);
        chk("rst_winner", 4'(w_winner5), 4'h0);
        r_rst = 1'b0;
        r_start = 1'b0;
        step();

        // 2: menu -> battle after two frames of dwell
        tick(); tick();
        pulse_start();
        chk("m2b_pend", 4'(w_pend5), 4'h1);
        chk("m2b_sel_wait", 4'(w_sel5), 4'h0);
        exp_q.push_back('{sel: 2'b01, start: 3'b010, winner: 1'b0});
        r_vs = 1'b1;
        step();
        chk("m2b_sel", 4'(w_sel5), 4'h1);
        chk("m2b_pend_clr", 4'(w_pend5), 4'h0);
        r_vs = 1'b0;
        step();
        chk("m2b_pulse_clr", 4'(w_start5), 4'h0);

        // 3: MIN_FRAMES guard, then accepted battle_over with winner P2
        tick();
        battle_over(1'b1);
        chk("guard_pend", 4'(w_pend5), 4'h0);
        chk("guard_winner", 4'(w_winner5), 4'h0);
        tick();
        battle_over(1'b1);
        chk("b2e_pend", 4'(w_pend5), 4'h1);
        chk("b2e_winner", 4'(w_winner5), 4'h1);
        exp_q.push_back('{sel: 2'b10, start: 3'b100, winner: 1'b1});
        tick();
        chk("b2e_sel", 4'(w_sel5), 4'h2);

        // 4: endgame timeout after 5 frames
        repeat (4) tick();
        chk("eg_pend_4", 4'(w_pend5), 4'h0);
        tick();
        chk("eg_pend_5", 4'(w_pend5), 4'h1);
        chk("eg_sel_wait", 4'(w_sel5), 4'h2);
        exp_q.push_back('{sel: 2'b00, start: 3'b001, winner: 1'b1});
        tick();
        chk("eg_sel", 4'(w_sel5), 4'h0);
        chk("eg_winner_held", 4'(w_winner5), 4'h1);

        // 5: event on the tick cycle commits only at the following tick
        tick(); tick();
        r_start = 1'b1;
        r_vs    = 1'b1;
        step();
        chk("same_sel", 4'(w_sel5), 4'h0);
        chk("same_pend", 4'(w_pend5), 4'h1);
        r_start = 1'b0;
        r_vs    = 1'b0;
        step();
        exp_q.push_back('{sel: 2'b01, start: 3'b010, winner: 1'b1});
        tick();
        chk("same_sel_next", 4'(w_sel5), 4'h1);

        // 6: reset while a battle request is pending
        r_rst = 1'b1;
        step();
        r_rst = 1'b0;
        chk("rst2_winner", 4'(w_winner5), 4'h0);
        tick(); tick();
        pulse_start();
        chk("rp_pend", 4'(w_pend5), 4'h1);
        r_rst = 1'b1;
        step();
        r_rst = 1'b0;
        chk("rp_pend_clr", 4'(w_pend5), 4'h0);
        chk("rp_sel", 4'(w_sel5), 4'h0);
        repeat (3) tick();
        chk("rp_sel_after", 4'(w_sel5), 4'h0);

        // 4b: endgame with timeout disabled stays put; restart still works
        pulse_start();
        exp_q.push_back('{sel: 2'b01, start: 3'b010, winner: 1'b0});
        tick();
        tick(); tick();
        battle_over(1'b0);
        exp_q.push_back('{sel: 2'b10, start: 3'b100, winner: 1'b0});
        tick();
        chk("nt_sel0_eg", 4'(w_sel0), 4'h2);
        exp_q.push_back('{sel: 2'b00, start: 3'b001, winner: 1'b0});
        repeat (10) tick();
        chk("nt_sel5", 4'(w_sel5), 4'h0);
        chk("nt_sel0", 4'(w_sel0), 4'h2);
        chk("nt_pend0", 4'(w_pend0), 4'h0);
        r_restart = 1'b1;
        step();
        r_restart = 1'b0;
        chk("rs_pend0", 4'(w_pend0), 4'h1);
        chk("rs_pend5", 4'(w_pend5), 4'h0);
        tick();
        chk("rs_sel0", 4'(w_sel0), 4'h0);

        repeat (3) step();
        chk("queue_empty", 4'(exp_q.size()), 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
